tick_duration_timer: RTL
========================

Name: tick_duration_timer

Overview:
Consumer end of the slow divided-frequency signal. It resynchronises the slow square wave produced by the clock divider into the system clock domain and turns each rising edge into a one-cycle tick strobe. Those ticks time a programmable countdown, which the irrigation controller uses to hold valves open for a set number of slow periods. A start/busy/done handshake controls the countdown, and an abort input ends it early.

Parameters:
WIDTH, 8, width of the duration and remaining counters, in slow-clock periods
SYNC_STAGES, 2, synchroniser depth for tick_in; legal values are 2 or 3

Ports:
clock  input  1  system clock; all logic is on its rising edge
reset  input  1  synchronous, active-high reset
tick_in  input  1  slow divided-frequency level signal, asynchronous to clock
start  input  1  request to load duration and begin counting; sampled only in IDLE
duration  input  WIDTH  number of ticks to count; captured on the accepted start
abort  input  1  ends an active countdown without asserting done
busy  output  1  high in RUN
done  output  1  one-cycle pulse when the countdown expires naturally
remaining  output  WIDTH  ticks left; holds its value after abort
tick_pulse  output  1  one-cycle strobe per synchronised rising edge of tick_in

Behaviour:
- Reset (synchronous, active-high):
  - busy=0, done=0, remaining=0, tick_pulse=0, state=IDLE.
  - All synchroniser flops and the edge-history flop clear to 0.
- Synchroniser:
  - SYNC_STAGES flops feed an edge-history flop.
  - tick_pulse = last sync stage & ~history, registered.
  - Latency from a tick_in rise to tick_pulse high is SYNC_STAGES+1 clocks.
  - tick_in high pulses shorter than one clock period may be missed; this is acceptable.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On start=1 with duration≠0: remaining←duration, go to RUN (busy=1 on the next cycle).
  - On start=1 with duration=0: go directly to DONE; remaining stays 0.
- RUN:
  - Each tick_pulse decrements remaining by 1.
  - If tick_pulse=1 and remaining=1: remaining←0 and go to DONE.
  - abort=1 goes to IDLE and freezes remaining. Abort has priority over a simultaneous tick.
  - start is ignored in RUN; duration is not re-sampled.
- DONE:
  - done=1 for exactly this one cycle, busy=0.
  - Unconditionally go to IDLE. start is ignored in this cycle.
  - abort has no effect in DONE.
- done is never asserted on the abort path.
- remaining never wraps: decrement is suppressed at 0, which is unreachable in RUN but guarded anyway.
- The synchroniser runs in every state. Ticks that arrive in IDLE or DONE are reported on tick_pulse but not counted.
- A tick_pulse in the same cycle as the start acceptance is not counted. Counting starts from the first RUN cycle.
- Reset mid-RUN returns to IDLE with remaining=0 and no done pulse.

Decomposition:
- A shared package holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - WIDTH_DEFAULT;
  - SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=3, with an elaboration check on SYNC_STAGES.
- One sub-module, edge_sync_pulse (synchroniser plus rising-edge detector, parameterised by SYNC_STAGES), which the FSM/counter top instantiates. Other blocks that consume slow divided signals reuse it.

Test Plan:
- Reset, then toggle tick_in every 20 clocks for 200 clocks with no start -> 5 tick_pulse strobes, each 1 cycle wide and 3 clocks after each tick_in rise (SYNC_STAGES=2); busy and done stay 0; remaining=0.
- start with duration=3, tick_in period 40 clocks -> busy rises next cycle; remaining steps 3→2→1→0 on successive ticks; done pulses for exactly 1 cycle after the third tick; busy=0 afterwards.
- start with duration=0 -> done pulses on the cycle after start; busy is never asserted.
- duration=5, assert abort after 2 ticks -> returns to IDLE, remaining=3, done is never asserted; a second start with duration=2 then completes normally.
- abort asserted in the same cycle as a tick_pulse with remaining=1 -> no done, remaining=1; also assert start during RUN and during DONE -> ignored, with no reload of duration.
- Assert reset mid-RUN with remaining=4 -> next cycle busy=0, remaining=0, state=IDLE, no done; WIDTH=4 with duration=15 counts 15 ticks with no wrap.

Source files
------------

// File: rtl/tick_duration_timer_pkg.sv
// Shared types and limits for the tick duration timer.
// Imported by the synchroniser and the countdown top.
package tick_duration_timer_pkg;

  localparam int WIDTH_DEFAULT       = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit sync_stages_ok(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/tick_duration_timer_edge_sync_pulse.sv
// Resynchronises a slow asynchronous level and emits a
// registered one-cycle strobe on each of its rising edges.
module edge_sync_pulse
  import tick_duration_timer_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_stages
    $error("edge_sync_pulse: SYNC_STAGES must be 2 or 3");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Synchroniser chain, edge history and registered rise strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_last;
      pulse  <= sync_last & ~hist_q;
    end
  end

endmodule

// File: rtl/tick_duration_timer.sv
// Countdown of slow-clock ticks with start/busy/done
// handshake and early abort.
module tick_duration_timer
  import tick_duration_timer_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             start,
  input  logic [WIDTH-1:0] duration,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining,
  output logic             tick_pulse
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] rem_q;
  logic             tick;
  logic             rem_is_one;
  logic             accept;
  logic             count;

  edge_sync_pulse #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset   (reset),
    .async_in(tick_in),
    .pulse   (tick)
  );

  assign tick_pulse = tick;
  assign remaining  = rem_q;
  assign rem_is_one = (rem_q == WIDTH'(1));
  assign accept     = (state_q == IDLE) && start;
  assign count      = (state_q == RUN) && !abort
                    && tick && (rem_q != '0);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: abort beats a same-cycle final tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (duration != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort)                   state_d = IDLE;
        else if (tick && rem_is_one) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Remaining count: load on accepted start, never wraps.
  always_ff @(posedge clock) begin
    if (reset)      rem_q <= '0;
    else if (accept) rem_q <= duration;
    else if (count)  rem_q <= rem_q - WIDTH'(1);
  end

  // Moore outputs decoded from state.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

endmodule
